stream_scoreboard: RTL and testbench
====================================

STREAM_SCOREBOARD -- requirements
Module: stream_scoreboard

Interface
REQ-001 SHALL have parameter W, default 64, data word width.
REQ-002 SHALL have parameter NUM_SEG, default 8, maximum output segments per run (2..16).
REQ-003 SHALL have parameter CNT_W, default 10, per-segment word-count width.
REQ-004 SHALL have parameter CYC_W, default 32, cycle-counter width.
REQ-005 SHALL have parameter TIMEOUT, default 2**20, maximum cycles per run.
REQ-006 SHALL use one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-007 Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  run-start pulse
- load_len  in  CNT_W  input words to load
- seg_num  in  clog2(NUM_SEG+1)  segments to unload
- seg_len  in  NUM_SEG*CNT_W  words per segment, seg 0 in LSBs
- stall_en  in  1  sink back-pressure enable
- in_valid  in  1  DUT input valid, observed
- in_ready  in  1  DUT input ready, observed
- out_valid  in  1  DUT output valid
- out_data  in  W  DUT output word
- out_ready  out  1  sink ready driven to DUT
- exp_seg  out  clog2(NUM_SEG)  expected-word segment index
- exp_idx  out  CNT_W  expected-word index
- exp_data  in  W  expected word, combinational from exp_seg/exp_idx
- busy  out  1  run in progress
- done  out  1  one-cycle run-complete pulse
- failed  out  1  any mismatch or timeout in last run
- timeout  out  1  last run hit TIMEOUT
- err_cnt  out  CNT_W  mismatch count, saturating
- first_err_seg, first_err_idx  out  clog2(NUM_SEG), CNT_W  location of first mismatch
- load_cyc, exec_cyc, unload_cyc, total_cyc  out  CYC_W each  phase cycle counts

Function
REQ-008 SHALL implement FSM IDLE, LOAD, EXEC, UNLOAD, DONE.
REQ-009 IDLE: on start, latch load_len, seg_num, seg_len, stall_en; clear all result outputs and counters; go to LOAD.
REQ-010 start SHALL be ignored outside IDLE.
REQ-011 LOAD: count beats where in_valid && in_ready; on beat count == load_len go to EXEC in the next cycle; load_len 0 goes directly to EXEC.
REQ-012 EXEC: out_ready asserted (subject to REQ-015); first cycle with out_valid && out_ready SHALL be counted as an UNLOAD beat and move to UNLOAD.
REQ-013 UNLOAD: each out_valid && out_ready beat SHALL compare out_data to exp_data for current (exp_seg, exp_idx), then advance exp_idx; at exp_idx == seg_len[exp_seg]-1, exp_idx wraps to 0 and exp_seg increments.
REQ-014 Segments with seg_len 0 SHALL be skipped, one segment per cycle, without beats; the final beat of the last non-empty segment, or seg_num 0, SHALL transition to DONE.
REQ-015 out_ready SHALL be 1 in EXEC and UNLOAD, except when stall_en: it toggles each cycle, starting 1; 0 in IDLE, LOAD, DONE.
REQ-016 On mismatch: err_cnt increments, saturating at all-ones; first_err_seg/idx captured only on the first mismatch; failed set.
REQ-017 load_cyc counts LOAD cycles, exec_cyc EXEC cycles, unload_cyc UNLOAD cycles, total_cyc all non-IDLE/DONE cycles; all saturate at all-ones.
REQ-018 If total_cyc reaches TIMEOUT in any phase, SHALL set timeout and failed and go to DONE.
REQ-019 DONE: assert done for exactly one cycle, return to IDLE; results hold until next accepted start.
REQ-020 busy SHALL be 1 in LOAD, EXEC, UNLOAD.
REQ-021 out_valid beats in IDLE, LOAD or DONE SHALL be ignored.

Reset
REQ-022 rst_n low SHALL asynchronously force IDLE and zero every output and counter, including mid-run; no done pulse is produced for an aborted run.

Verification
REQ-023 load_len=4, seg_num=2, seg_len={3,2}, all data matching, no stall -> done one cycle after 5th out beat, failed=0, err_cnt=0, load_cyc=4 with continuous in beats.
REQ-024 Same run with seg1 idx0 corrupted -> failed=1, err_cnt=1, first_err_seg=1, first_err_idx=0.
REQ-025 seg_len={2,0,3}, seg_num=3 -> exp_seg goes 0 then 2; 5 beats checked; done asserted.
REQ-026 stall_en=1, DUT holds out_valid=1 -> out_ready alternates 1,0,1,...; unload_cyc approx. 2x the beat count.
REQ-027 TIMEOUT=64, DUT never asserts out_valid -> timeout=1, failed=1, done at total_cyc=64.
REQ-028 rst_n low during UNLOAD -> immediate IDLE, all outputs 0; new start then runs normally.

Source files
------------

// File: rtl/stream_scoreboard.sv
// stream_scoreboard
//   Run-level checker for a streaming DUT. A run is started with a pulse on
//   `start`; the block then watches the DUT consume `load_len` input words,
//   waits for the first output word, and compares every output word against
//   an externally supplied expected word addressed by (exp_seg, exp_idx).
//   Output words are grouped into up to NUM_SEG segments of seg_len words.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 run-start pulse (honoured only when idle)
//   load_len              number of input beats to observe before EXEC
//   seg_num, seg_len      number of output segments and their lengths
//                         (segment 0 in the LSBs of seg_len)
//   stall_en              alternate out_ready 1,0,1,... during unload
//   in_valid, in_ready    observed DUT input handshake
//   out_valid, out_data   DUT output stream
//   out_ready             sink ready driven back to the DUT
//   exp_seg, exp_idx      address of the expected word
//   exp_data              expected word (combinational from exp_seg/exp_idx)
//   busy, done            run in progress / one-cycle completion pulse
//   failed, timeout       result flags of the last run
//   err_cnt               saturating mismatch count
//   first_err_seg/idx     location of the first mismatch
//   load_cyc .. total_cyc saturating phase cycle counters
//   state_dbg             current FSM state, for checkers
//
// Handshake: a beat happens on a rising clk edge where valid && ready are
// both high; valid and data are owned by the producer, ready by the sink.
module stream_scoreboard #(
  parameter int W       = 64,
  parameter int NUM_SEG = 8,
  parameter int CNT_W   = 10,
  parameter int CYC_W   = 32,
  parameter int TIMEOUT = 2**20,
  localparam int SN_W   = $clog2(NUM_SEG + 1),
  localparam int SG_W   = $clog2(NUM_SEG)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         load_len,
  input  logic [SN_W-1:0]          seg_num,
  input  logic [NUM_SEG*CNT_W-1:0] seg_len,
  input  logic                     stall_en,
  input  logic                     in_valid,
  input  logic                     in_ready,
  input  logic                     out_valid,
  input  logic [W-1:0]             out_data,
  output logic                     out_ready,
  output logic [SG_W-1:0]          exp_seg,
  output logic [CNT_W-1:0]         exp_idx,
  input  logic [W-1:0]             exp_data,
  output logic                     busy,
  output logic                     done,
  output logic                     failed,
  output logic                     timeout,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [SG_W-1:0]          first_err_seg,
  output logic [CNT_W-1:0]         first_err_idx,
  output logic [CYC_W-1:0]         load_cyc,
  output logic [CYC_W-1:0]         exec_cyc,
  output logic [CYC_W-1:0]         unload_cyc,
  output logic [CYC_W-1:0]         total_cyc,
  output logic [2:0]               state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_EXEC   = 3'd2,
    S_UNLOAD = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [CYC_W-1:0] TO_LIM = CYC_W'(TIMEOUT);

  state_t state_q, state_d;

  // Run configuration captured at start
  logic [CNT_W-1:0] load_len_q;
  logic [SN_W-1:0]  seg_num_q;
  logic [CNT_W-1:0] seg_len_q [NUM_SEG];
  logic             stall_q;

  logic [CNT_W-1:0] load_cnt_q;
  logic             tog_q;

  logic             active, unl, in_beat, cur_empty, more_after;
  logic             last_idx, beat, mismatch, to_hit;
  logic [CNT_W-1:0] cur_len;
  logic [CYC_W-1:0] total_nx;

  function automatic logic [CYC_W-1:0] sat_cyc(input logic [CYC_W-1:0] v);
    return (v == '1) ? v : v + CYC_W'(1);
  endfunction

  always_comb begin
    active   = (state_q == S_LOAD) || (state_q == S_EXEC) || (state_q == S_UNLOAD);
    unl      = (state_q == S_EXEC) || (state_q == S_UNLOAD);
    in_beat  = (state_q == S_LOAD) && in_valid && in_ready;
    cur_len  = seg_len_q[exp_seg];
    // Is there any non-empty segment beyond the current one? Lets the last
    // beat go straight to DONE instead of walking trailing empty segments.
    more_after = 1'b0;
    for (int s = 0; s < NUM_SEG; s++) begin
      if ((SG_W'(s) > exp_seg) && (SN_W'(s) < seg_num_q) && (seg_len_q[s] != '0))
        more_after = 1'b1;
    end
    cur_empty = (seg_num_q == '0) || (cur_len == '0);
    last_idx  = (exp_idx == cur_len - CNT_W'(1));
    // Ready is held low on skip cycles so no output word is consumed while
    // the address is moving past an empty segment.
    out_ready = unl && !cur_empty && (!stall_q || tog_q);
    beat      = out_ready && out_valid;
    mismatch  = beat && (out_data != exp_data);
    total_nx  = sat_cyc(total_cyc);
    to_hit    = active && (total_nx >= TO_LIM);
    busy      = active;
    done      = (state_q == S_DONE);
    state_dbg = state_q;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (load_len == '0) ? S_EXEC : S_LOAD;
      end
      S_LOAD: begin
        if (in_beat && (load_cnt_q + CNT_W'(1) == load_len_q)) state_d = S_EXEC;
      end
      S_EXEC, S_UNLOAD: begin
        if (cur_empty && !more_after)               state_d = S_DONE;
        else if (beat && last_idx && !more_after)   state_d = S_DONE;
        else if (beat)                              state_d = S_UNLOAD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (to_hit) state_d = S_DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Datapath: configuration, expected-word address, results, counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_len_q    <= '0;
      seg_num_q     <= '0;
      for (int s = 0; s < NUM_SEG; s++) seg_len_q[s] <= '0;
      stall_q       <= 1'b0;
      load_cnt_q    <= '0;
      tog_q         <= 1'b0;
      exp_seg       <= '0;
      exp_idx       <= '0;
      failed        <= 1'b0;
      timeout       <= 1'b0;
      err_cnt       <= '0;
      first_err_seg <= '0;
      first_err_idx <= '0;
      load_cyc      <= '0;
      exec_cyc      <= '0;
      unload_cyc    <= '0;
      total_cyc     <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      load_len_q    <= load_len;
      seg_num_q     <= (seg_num > SN_W'(NUM_SEG)) ? SN_W'(NUM_SEG) : seg_num;
      for (int s = 0; s < NUM_SEG; s++) seg_len_q[s] <= seg_len[s*CNT_W +: CNT_W];
      stall_q       <= stall_en;
      load_cnt_q    <= '0;
      tog_q         <= 1'b1;
      exp_seg       <= '0;
      exp_idx       <= '0;
      failed        <= 1'b0;
      timeout       <= 1'b0;
      err_cnt       <= '0;
      first_err_seg <= '0;
      first_err_idx <= '0;
      load_cyc      <= '0;
      exec_cyc      <= '0;
      unload_cyc    <= '0;
      total_cyc     <= '0;
    end else begin
      if (in_beat) load_cnt_q <= load_cnt_q + CNT_W'(1);

      if (state_q == S_LOAD)   load_cyc   <= sat_cyc(load_cyc);
      if (state_q == S_EXEC)   exec_cyc   <= sat_cyc(exec_cyc);
      if (state_q == S_UNLOAD) unload_cyc <= sat_cyc(unload_cyc);
      if (active)              total_cyc  <= total_nx;

      if (unl) tog_q <= ~tog_q;

      if (unl && cur_empty && more_after) begin
        exp_seg <= exp_seg + SG_W'(1);
        exp_idx <= '0;
      end

      if (beat) begin
        if (mismatch) begin
          failed <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
          if (err_cnt == '0) begin
            first_err_seg <= exp_seg;
            first_err_idx <= exp_idx;
          end
        end
        // The address holds on the final beat of the run.
        if (!last_idx) begin
          exp_idx <= exp_idx + CNT_W'(1);
        end else if (more_after) begin
          exp_seg <= exp_seg + SG_W'(1);
          exp_idx <= '0;
        end
      end

      if (to_hit) begin
        timeout <= 1'b1;
        failed  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_scoreboard.sv
module tb_stream_scoreboard;
  localparam int W       = 16;
  localparam int NUM_SEG = 4;
  localparam int CNT_W   = 8;
  localparam int CYC_W   = 16;
  localparam int TIMEOUT = 64;
  localparam int SN_W    = $clog2(NUM_SEG + 1);
  localparam int SG_W    = $clog2(NUM_SEG);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                     start = 1'b0;
  logic [CNT_W-1:0]         load_len = '0;
  logic [SN_W-1:0]          seg_num = '0;
  logic [NUM_SEG*CNT_W-1:0] seg_len = '0;
  logic                     stall_en = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready = 1'b0;
  logic                     out_valid = 1'b0;
  logic [W-1:0]             out_data = '0;
  logic                     out_ready;
  logic [SG_W-1:0]          exp_seg;
  logic [CNT_W-1:0]         exp_idx;
  logic [W-1:0]             exp_data;
  logic                     busy, done, failed, timeout;
  logic [CNT_W-1:0]         err_cnt;
  logic [SG_W-1:0]          first_err_seg;
  logic [CNT_W-1:0]         first_err_idx;
  logic [CYC_W-1:0]         load_cyc, exec_cyc, unload_cyc, total_cyc;
  logic [2:0]               state_dbg;

  stream_scoreboard #(
    .W(W), .NUM_SEG(NUM_SEG), .CNT_W(CNT_W), .CYC_W(CYC_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
    .seg_num(seg_num), .seg_len(seg_len), .stall_en(stall_en),
    .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .exp_seg(exp_seg),
    .exp_idx(exp_idx), .exp_data(exp_data), .busy(busy), .done(done),
    .failed(failed), .timeout(timeout), .err_cnt(err_cnt),
    .first_err_seg(first_err_seg), .first_err_idx(first_err_idx),
    .load_cyc(load_cyc), .exec_cyc(exec_cyc), .unload_cyc(unload_cyc),
    .total_cyc(total_cyc), .state_dbg(state_dbg)
  );

  // Reference word for segment s, index i (acts as the expected-data memory)
  function automatic logic [W-1:0] word_of(input int s, input int i);
    return W'(32'hA000 + s * 256 + i * 3);
  endfunction

  assign exp_data = word_of(int'(exp_seg), int'(exp_idx));

  // ---------------- scoreboard / model state ----------------
  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];    // expected {seg, idx} location of each beat
  logic [W-1:0] src_q[$];    // words the simulated DUT will emit
  int c_len[NUM_SEG];
  int m_beats, m_err, m_fseg, m_fidx, m_load, m_exec, m_unload, m_total, m_tmo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Predict a run from its configuration: which locations are checked in
  // which order, the error tally, and how many cycles each phase lasts.
  task automatic build_model(input int ll, input int sn, input bit st,
                             input int cmask, input bit silent);
    int last_ne, cyc, first_cyc;
    bit ph, got_first;
    exp_q.delete();
    src_q.delete();
    m_beats = 0; m_err = 0; m_fseg = 0; m_fidx = 0;
    last_ne = -1;
    for (int s = 0; s < sn; s++) begin
      if (c_len[s] > 0) last_ne = s;
      for (int i = 0; i < c_len[s]; i++) begin
        logic [W-1:0] w;
        w = word_of(s, i);
        exp_q.push_back(W'(s * 256 + i));
        if (cmask[m_beats]) begin
          w = w ^ 16'h0F0F;
          if (m_err == 0) begin m_fseg = s; m_fidx = i; end
          m_err++;
        end
        src_q.push_back(w);
        m_beats++;
      end
    end
    m_load = ll;
    m_tmo  = 0;
    if (silent) begin
      m_err = 0; m_fseg = 0; m_fidx = 0;
      m_exec = TIMEOUT - ll; m_unload = 0; m_total = TIMEOUT; m_tmo = 1;
    end else if (m_beats == 0) begin
      m_exec = 1; m_unload = 0; m_total = ll + 1;
    end else begin
      // Visited segments: empty ones cost one cycle, words cost one cycle
      // each, and with stall the sink is ready only on alternate cycles.
      cyc = 0; ph = 1'b1; got_first = 1'b0; first_cyc = 0;
      for (int s = 0; s <= last_ne; s++) begin
        if (c_len[s] == 0) begin
          cyc++; ph = ~ph;
        end else begin
          for (int i = 0; i < c_len[s]; i++) begin
            while (st && !ph) begin cyc++; ph = ~ph; end
            cyc++; ph = ~ph;
            if (!got_first) begin got_first = 1'b1; first_cyc = cyc; end
          end
        end
      end
      m_exec = first_cyc; m_unload = cyc - first_cyc; m_total = ll + cyc;
    end
  endtask

  // ---------------- driver + per-cycle compare ----------------
  task automatic run(input int ll, input int sn, input bit st, input int cmask,
                     input bit silent, input bit mid_start, input int abort_at);
    int k, last_beat;
    bit beat_pend, got_done;
    logic [W-1:0] e;
    build_model(ll, sn, st, cmask, silent);
    @(negedge clk);
    load_len = CNT_W'(ll);
    seg_num  = SN_W'(sn);
    for (int s = 0; s < NUM_SEG; s++) seg_len[s*CNT_W +: CNT_W] = CNT_W'(c_len[s]);
    stall_en  = st;
    in_valid  = 1'b1;
    in_ready  = 1'b1;
    out_valid = !silent && (src_q.size() > 0);
    out_data  = (src_q.size() > 0) ? src_q[0] : '0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0; last_beat = -1; beat_pend = 1'b0; got_done = 1'b0;
    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      if (beat_pend) begin
        k++;
        if (k < src_q.size()) out_data = src_q[k];
        else begin out_data = '0; out_valid = 1'b0; end
      end
      beat_pend = 1'b0;
      if (mid_start) begin
        start = (cyc == 2);
        if (cyc == 2) begin load_len = 8'd7; seg_num = '0; end
      end
      if (abort_at > 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out_ready", out_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_failed", failed, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_exp_seg", exp_seg, 0);
        chk("rst_exp_idx", exp_idx, 0);
        chk("rst_unload_cyc", unload_cyc, 0);
        chk("rst_total_cyc", total_cyc, 0);
        chk("rst_state", state_dbg, 0);
        out_valid = 1'b0; in_valid = 1'b0;
        repeat (2) begin
          @(negedge clk);
          chk("rst_no_done", done, 0);
        end
        rst_n = 1'b1;
        return;
      end
      if (done) begin
        got_done = 1'b1;
        if (m_beats > 0 && !silent) chk("done_after_last_beat", cyc - last_beat, 1);
        if (!silent) chk("beats_left", exp_q.size(), 0);
        chk("err_cnt", err_cnt, m_err);
        chk("failed", failed, (m_err > 0 || m_tmo) ? 1 : 0);
        chk("timeout", timeout, m_tmo);
        chk("first_err_seg", first_err_seg, m_fseg);
        chk("first_err_idx", first_err_idx, m_fidx);
        chk("load_cyc", load_cyc, m_load);
        chk("exec_cyc", exec_cyc, m_exec);
        chk("unload_cyc", unload_cyc, m_unload);
        chk("total_cyc", total_cyc, m_total);
        chk("busy_at_done", busy, 0);
        chk("out_ready_at_done", out_ready, 0);
      end else begin
        chk("busy_in_run", busy, 1);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("extra_beat", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("beat_loc", 32'(exp_seg) * 256 + 32'(exp_idx), 32'(e));
          end
          if (st && last_beat >= 0) chk("stall_gap", cyc - last_beat, 2);
          last_beat = cyc;
          beat_pend = 1'b1;
        end
      end
      @(negedge clk);
    end
    if (!got_done) chk("done_seen", 0, 1);
    else begin
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", busy, 0);
    end
    start = 1'b0; out_valid = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_out_ready", out_ready, 0);
    chk("reset_total", total_cyc, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic run, all matching
    c_len = '{3, 2, 0, 0};
    run(4, 2, 1'b0, 0, 1'b0, 1'b0, 0);
    chk("t1_total_lit", total_cyc, 9);
    chk("t1_load_lit", load_cyc, 4);
    chk("t1_failed_lit", failed, 0);

    // seg1 idx0 corrupted
    run(4, 2, 1'b0, 32'b01000, 1'b0, 1'b0, 0);
    chk("t2_err_lit", err_cnt, 1);
    chk("t2_fseg_lit", first_err_seg, 1);
    chk("t2_fidx_lit", first_err_idx, 0);

    // Two corruptions: first location wins, count keeps going
    run(4, 2, 1'b0, 32'b10010, 1'b0, 1'b0, 0);
    chk("t2b_err_lit", err_cnt, 2);
    chk("t2b_fidx_lit", first_err_idx, 1);

    // Empty middle segment
    c_len = '{2, 0, 3, 0};
    run(2, 3, 1'b0, 0, 1'b0, 1'b0, 0);
    chk("t3_total_lit", total_cyc, 8);
    chk("t3_seg_lit", exp_seg, 2);

    // Sink stall
    c_len = '{3, 3, 0, 0};
    run(1, 2, 1'b1, 0, 1'b0, 1'b0, 0);
    chk("t4_unload_lit", unload_cyc, 10);

    // Output never arrives -> timeout
    c_len = '{2, 0, 0, 0};
    run(2, 1, 1'b0, 0, 1'b1, 1'b0, 0);
    chk("t5_total_lit", total_cyc, 64);
    chk("t5_timeout_lit", timeout, 1);

    // No segments, no load
    c_len = '{0, 0, 0, 0};
    run(0, 0, 1'b0, 0, 1'b0, 1'b0, 0);
    chk("t6_total_lit", total_cyc, 1);

    // start pulsed mid-run with different config must be ignored
    c_len = '{3, 2, 0, 0};
    run(4, 2, 1'b0, 0, 1'b0, 1'b1, 0);

    // Reset during unload, then a normal run
    c_len = '{8, 0, 0, 0};
    run(1, 1, 1'b0, 0, 1'b0, 1'b0, 3);
    c_len = '{3, 2, 0, 0};
    run(4, 2, 1'b0, 32'b00001, 1'b0, 1'b0, 0);
    chk("t8_err_lit", err_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
